// File: rtl/approx_eval_pkg.sv
// Shared types and helpers for the approximate-circuit error sweeper.
// Width localparams reflect the default 4-input/3-output configuration.
package approx_eval_pkg;

  localparam int N_IN_DEF  = 4;
  localparam int N_OUT_DEF = 3;
  localparam int ERR_W     = N_OUT_DEF;
  localparam int SUM_W     = N_OUT_DEF + N_IN_DEF;
  localparam int CNT_W     = N_IN_DEF + 1;
  localparam int ABS_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } sweep_state_t;

  // Operands are zero-extended to ABS_W so one helper serves any N_OUT up to 16.
  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                input logic [ABS_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/approx_error_sweeper_err_accum.sv
// Sample register plus error accumulators (max, sum, violation count/first index).
// A synchronous clr empties the sample stage and zeroes every result.
module err_accum
  import approx_eval_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [N_IN-1:0]       in_idx,
  input  logic [N_OUT-1:0]      exact_in,
  input  logic [N_OUT-1:0]      approx_in,
  input  logic [N_OUT-1:0]      et,
  output logic [N_OUT-1:0]      max_err,
  output logic [N_OUT+N_IN-1:0] err_sum,
  output logic [N_IN:0]         viol_count,
  output logic [N_IN-1:0]       first_viol_vec
);

  localparam int SUM_WID = N_OUT + N_IN;

  logic             s_valid;
  logic [N_IN-1:0]  s_idx;
  logic [N_OUT-1:0] s_exact;
  logic [N_OUT-1:0] s_approx;
  logic [ABS_W-1:0] diff;
  logic             over;

  assign diff = abs_diff(ABS_W'(s_exact), ABS_W'(s_approx));
  assign over = diff > ABS_W'(et);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid  <= 1'b0;
      s_idx    <= '0;
      s_exact  <= '0;
      s_approx <= '0;
    end else if (clr) begin
      s_valid  <= 1'b0;
    end else begin
      s_valid  <= in_valid;
      s_idx    <= in_idx;
      s_exact  <= exact_in;
      s_approx <= approx_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_err        <= '0;
      err_sum        <= '0;
      viol_count     <= '0;
      first_viol_vec <= '0;
    end else if (clr) begin
      max_err        <= '0;
      err_sum        <= '0;
      viol_count     <= '0;
      first_viol_vec <= '0;
    end else if (s_valid) begin
      if (diff > ABS_W'(max_err)) max_err <= diff[N_OUT-1:0];
      err_sum <= err_sum + SUM_WID'(diff);
      if (over) begin
        viol_count <= viol_count + 1'b1;
        // Vectors arrive in ascending order, so the first hit is the lowest index.
        if (viol_count == '0) first_viol_vec <= s_idx;
      end
    end
  end

endmodule

// File: rtl/approx_error_sweeper.sv
// Sweep controller: walks every input vector, tags samples through the
// circuit latency and hands them to err_accum.
//
// state | meaning
// IDLE  | waiting for start; results held
// SWEEP | presenting vectors 0 .. 2^N_IN-1
// DRAIN | flushing DUT_LAT+2 cycles of in-flight samples
// DONE  | one-cycle done pulse, results final
module approx_error_sweeper
  import approx_eval_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int N_OUT   = N_OUT_DEF,
  parameter int DUT_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [N_OUT-1:0]      et,
  output logic [N_IN-1:0]       vec_out,
  input  logic [N_OUT-1:0]      exact_in,
  input  logic [N_OUT-1:0]      approx_in,
  output logic                  busy,
  output logic                  done,
  output logic [N_OUT-1:0]      max_err,
  output logic [N_OUT+N_IN-1:0] err_sum,
  output logic [N_IN:0]         viol_count,
  output logic                  viol,
  output logic [N_IN-1:0]       first_viol_vec
);

  localparam logic [N_IN-1:0] VEC_LAST   = '1;
  localparam logic [2:0]      DRAIN_INIT = 3'(DUT_LAT + 1);

  sweep_state_t     state, state_nxt;
  logic             clr;
  logic             et_load;
  logic [N_OUT-1:0] et_q;
  logic [2:0]       drain_cnt;
  logic             sweep_valid;
  logic             tag_valid;
  logic [N_IN-1:0]  tag_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    et_load   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SWEEP;
          clr       = 1'b1;
          et_load   = 1'b1;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_nxt = IDLE;
          clr       = 1'b1;
        end else if (vec_out == VEC_LAST) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_nxt = IDLE;
          clr       = 1'b1;
        end else if (drain_cnt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_out   <= '0;
      et_q      <= '0;
      drain_cnt <= '0;
    end else begin
      if (et_load) et_q <= et;
      if (clr)
        vec_out <= '0;
      else if (state == SWEEP && state_nxt == SWEEP)
        vec_out <= vec_out + 1'b1;
      if (state == SWEEP && state_nxt == DRAIN)
        drain_cnt <= DRAIN_INIT;
      else if (state == DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - 1'b1;
    end
  end

  assign busy        = (state == SWEEP) || (state == DRAIN);
  assign done        = (state == DONE);
  assign sweep_valid = (state == SWEEP);

  // Tag line: each vector index rides alongside the circuit latency so the
  // sample register sees the index that produced its exact/approx pair.
  if (DUT_LAT == 0) begin : g_no_lat
    assign tag_valid = sweep_valid;
    assign tag_idx   = vec_out;
  end else begin : g_lat
    logic [DUT_LAT-1:0] dl_valid;
    logic [N_IN-1:0]    dl_idx [DUT_LAT];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dl_valid <= '0;
        for (int i = 0; i < DUT_LAT; i++) dl_idx[i] <= '0;
      end else begin
        if (clr) begin
          dl_valid <= '0;
        end else begin
          dl_valid[0] <= sweep_valid;
          for (int i = 1; i < DUT_LAT; i++) dl_valid[i] <= dl_valid[i-1];
        end
        dl_idx[0] <= vec_out;
        for (int i = 1; i < DUT_LAT; i++) dl_idx[i] <= dl_idx[i-1];
      end
    end

    assign tag_valid = dl_valid[DUT_LAT-1];
    assign tag_idx   = dl_idx[DUT_LAT-1];
  end

  err_accum #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_err_accum (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr),
    .in_valid       (tag_valid),
    .in_idx         (tag_idx),
    .exact_in       (exact_in),
    .approx_in      (approx_in),
    .et             (et_q),
    .max_err        (max_err),
    .err_sum        (err_sum),
    .viol_count     (viol_count),
    .first_viol_vec (first_viol_vec)
  );

  assign viol = (viol_count != '0);

endmodule

// File: tb/tb_approx_error_sweeper.sv
// Scoreboard bench: two sweepers (latency 0 and 2) run side by side against
// an abs_diff reference circuit and an approximate version of it.
module tb_approx_error_sweeper;
  import approx_eval_pkg::*;

  typedef struct {
    int max_err;
    int err_sum;
    int viol_count;
    int viol;
    int first;
    int busy_len;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [ERR_W-1:0] et = '0;
  logic mode = 1'b0;

  logic [N_IN_DEF-1:0] d0_vec, d2_vec, d0_first, d2_first;
  logic [ERR_W-1:0]    d0_exact, d0_approx, d2_exact, d2_approx, d0_max, d2_max;
  logic [ERR_W-1:0]    e2_d1, e2_d2, a2_d1, a2_d2;
  logic [SUM_W-1:0]    d0_sum, d2_sum;
  logic [CNT_W-1:0]    d0_cnt, d2_cnt;
  logic d0_busy, d0_done, d0_viol, d2_busy, d2_done, d2_viol;

  int checks = 0;
  int errors = 0;
  int b0 = 0;
  int b2 = 0;
  exp_t q0[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  function automatic logic [ERR_W-1:0] absd(input logic [N_IN_DEF-1:0] v);
    int a, b;
    a = int'(v[1:0]);
    b = int'(v[3:2]);
    return (a > b) ? ERR_W'(a - b) : ERR_W'(b - a);
  endfunction

  // mode 0: approx equals exact; mode 1: approx tied to 0
  assign d0_exact  = absd(d0_vec);
  assign d0_approx = mode ? '0 : d0_exact;

  always @(posedge clk) begin
    e2_d1 <= absd(d2_vec);
    e2_d2 <= e2_d1;
    a2_d1 <= mode ? '0 : absd(d2_vec);
    a2_d2 <= a2_d1;
  end
  assign d2_exact  = e2_d2;
  assign d2_approx = a2_d2;

  approx_error_sweeper u_dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .et(et),
    .vec_out(d0_vec), .exact_in(d0_exact), .approx_in(d0_approx),
    .busy(d0_busy), .done(d0_done), .max_err(d0_max), .err_sum(d0_sum),
    .viol_count(d0_cnt), .viol(d0_viol), .first_viol_vec(d0_first)
  );

  approx_error_sweeper #(.DUT_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .et(et),
    .vec_out(d2_vec), .exact_in(d2_exact), .approx_in(d2_approx),
    .busy(d2_busy), .done(d2_done), .max_err(d2_max), .err_sum(d2_sum),
    .viol_count(d2_cnt), .viol(d2_viol), .first_viol_vec(d2_first)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input exp_t x, input int mx, input int sm,
                     input int cn, input int vl, input int fv, input int bs, input int bl);
    chk({tag, "_max_err"}, mx, x.max_err);
    chk({tag, "_err_sum"}, sm, x.err_sum);
    chk({tag, "_viol_count"}, cn, x.viol_count);
    chk({tag, "_viol"}, vl, x.viol);
    chk({tag, "_first_viol_vec"}, fv, x.first);
    chk({tag, "_busy_at_done"}, bs, 0);
    chk({tag, "_busy_len"}, bl, x.busy_len);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (d0_busy) b0++;
    if (d0_done) begin
      if (q0.size() == 0) chk("d0_unexpected_done", 1, 0);
      else begin
        x = q0.pop_front();
        cmp("d0", x, int'(d0_max), int'(d0_sum), int'(d0_cnt), int'(d0_viol),
            int'(d0_first), int'(d0_busy), b0);
      end
    end
    if (!d0_busy) b0 = 0;
  end

  always @(negedge clk) begin
    exp_t x;
    if (d2_busy) b2++;
    if (d2_done) begin
      if (q2.size() == 0) chk("d2_unexpected_done", 1, 0);
      else begin
        x = q2.pop_front();
        cmp("d2", x, int'(d2_max), int'(d2_sum), int'(d2_cnt), int'(d2_viol),
            int'(d2_first), int'(d2_busy), b2);
      end
    end
    if (!d2_busy) b2 = 0;
  end

  task automatic check_cleared(input string tag);
    chk({tag, "_d0_outputs"}, int'({d0_vec, d0_busy, d0_done, d0_max, d0_sum, d0_cnt, d0_viol, d0_first}), 0);
    chk({tag, "_d2_outputs"}, int'({d2_vec, d2_busy, d2_done, d2_max, d2_sum, d2_cnt, d2_viol, d2_first}), 0);
  endtask

  task automatic issue(input logic m, input int e, input int ab, input exp_t x);
    exp_t x2;
    mode  = m;
    et    = ERR_W'(e);
    abort = ab[0];
    start = 1'b1;
    x2 = x;
    x2.busy_len = 20;
    q0.push_back(x);
    q2.push_back(x2);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic start_only(input logic m, input int e);
    mode  = m;
    et    = ERR_W'(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drained();
    for (int i = 0; i < 100 && (q0.size() != 0 || q2.size() != 0); i++) @(negedge clk);
    chk("drain_timeout", q0.size() + q2.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_vec(input int v);
    for (int i = 0; i < 40 && int'(d0_vec) != v; i++) @(negedge clk);
    chk("wait_vec", int'(d0_vec), v);
  endtask

  initial begin
    exp_t zero_x, m1_et3, m1_et2;
    zero_x = '{0, 0, 0, 0, 0, 18};
    m1_et3 = '{3, 20, 0, 0, 0, 18};
    m1_et2 = '{3, 20, 2, 1, 3, 18};

    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 3, 0, zero_x);
    wait_drained();
    issue(1'b1, 3, 0, m1_et3);
    wait_drained();
    issue(1'b1, 2, 0, m1_et2);
    wait_drained();
    issue(1'b1, 7, 0, m1_et3);
    wait_drained();
    issue(1'b1, 0, 0, '{3, 20, 12, 1, 1, 18});
    wait_drained();

    // abort at vec_out=5, after vector 3 has already registered a violation
    start_only(1'b1, 2);
    wait_vec(5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_cleared("abort");
    repeat (25) @(negedge clk);

    // start and abort together in IDLE: start wins
    issue(1'b1, 2, 1, m1_et2);
    wait_drained();

    // start while busy is ignored; sweep length unchanged
    issue(1'b1, 2, 0, m1_et2);
    wait_vec(6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drained();

    // asynchronous reset mid-sweep
    start_only(1'b1, 2);
    wait_vec(5);
    rst = 1'b1;
    #1;
    check_cleared("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);

    issue(1'b1, 2, 0, m1_et2);
    wait_drained();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
